// File: rtl/iir_meter_pkg.sv
// Shared types and default widths for the IIR response meter.
// The result struct is sized for the default configuration.
package iir_meter_pkg;

   localparam int DW        = 18;
   localparam int PWR_W     = 2 * DW;
   localparam int NBINS_DEF = 256;
   localparam int BIN_W     = $clog2(NBINS_DEF);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } meter_state_t;

   typedef struct packed {
      logic [BIN_W-1:0] bin;
      logic [PWR_W-1:0] mean;
      logic [PWR_W-1:0] peak;
   } meter_result_t;

endpackage

// File: rtl/iir_response_meter_if.sv
// Sample-in / result-out bundle of the IIR response meter.
// The master drives the filter samples; the slave is the meter.
interface iir_response_meter_if #(
   parameter int DW    = iir_meter_pkg::DW,
   parameter int NBINS = iir_meter_pkg::NBINS_DEF
);

   logic                       sweep_start;
   logic                       dv_in;
   logic signed [DW-1:0]       d_real;
   logic signed [DW-1:0]       d_imag;
   logic                       dv_out;
   logic [$clog2(NBINS)-1:0]   bin;
   logic [2*DW-1:0]            mean_pwr;
   logic [2*DW-1:0]            peak_pwr;
   logic                       sweep_done;
   logic                       busy;

   modport master (
      output sweep_start, dv_in, d_real, d_imag,
      input  dv_out, bin, mean_pwr, peak_pwr, sweep_done, busy
   );

   modport slave (
      input  sweep_start, dv_in, d_real, d_imag,
      output dv_out, bin, mean_pwr, peak_pwr, sweep_done, busy
   );

endinterface

// File: rtl/iir_pwr_stage.sv
// Two-stage complex magnitude-squared pipeline: squares, then their sum.
// flush drops the sample moving from the square stage to the power stage.
module iir_pwr_stage #(
   parameter int DW = iir_meter_pkg::DW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 valid_in,
   input  logic signed [DW-1:0] re,
   input  logic signed [DW-1:0] im,
   output logic                 valid_out,
   output logic [2*DW-1:0]      pwr
);

   localparam int PW = 2 * DW;

   logic signed [PW-1:0] sq_re;
   logic signed [PW-1:0] sq_im;
   logic                 v1;

   // Operands are sign-extended to full width so the product is exact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= 1'b0;
         valid_out <= 1'b0;
         sq_re     <= '0;
         sq_im     <= '0;
         pwr       <= '0;
      end else begin
         v1        <= valid_in;
         valid_out <= v1 && !flush;
         if (valid_in) begin
            sq_re <= PW'(re) * PW'(re);
            sq_im <= PW'(im) * PW'(im);
         end
         if (v1) begin
            pwr <= $unsigned(sq_re) + $unsigned(sq_im);
         end
      end
   end

endmodule

// File: rtl/iir_response_meter.sv
// Windowed mean/peak power meter for the swept IIR filter output.
// Peak tracking is compiled in only when IIR_METER_PEAK_EN is defined.
module iir_response_meter #(
   parameter int LOG2_WIN = 10,
   parameter int NBINS    = 256,
   parameter int DW       = iir_meter_pkg::DW
) (
   input  logic                 clk,
   input  logic                 rst_n,
   iir_response_meter_if.slave  bus
);

   import iir_meter_pkg::*;

   localparam int PW = 2 * DW;
   localparam int AW = PW + LOG2_WIN;
   localparam int BW = $clog2(NBINS);
   localparam logic [BW-1:0] LAST_BIN = BW'(NBINS - 1);

   typedef struct packed {
      logic [BW-1:0] bin;
      logic [PW-1:0] mean;
      logic [PW-1:0] peak;
   } result_t;

   meter_state_t        state;
   meter_state_t        state_next;
   logic                accept;
   logic [LOG2_WIN-1:0] in_cnt;
   logic [BW-1:0]       in_bin;

   logic                p_valid;
   logic [PW-1:0]       p_pwr;
   logic [LOG2_WIN-1:0] s_cnt;
   logic [BW-1:0]       s_bin;
   logic [AW-1:0]       acc;
   logic [AW-1:0]       acc_sum;
   logic [PW-1:0]       peak_next;
   result_t             res;
   logic                res_dv;
   logic                res_done;

   assign accept = bus.dv_in && ((state == RUN) || bus.sweep_start);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.sweep_start) state_next = RUN;
         RUN: begin
            if (!bus.sweep_start && accept && (in_cnt == '1) && (in_bin == LAST_BIN)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Input-side position in the sweep; the sweep_start sample is sample 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt <= '0;
         in_bin <= '0;
      end else if (bus.sweep_start) begin
         in_cnt <= bus.dv_in ? LOG2_WIN'(1) : '0;
         in_bin <= '0;
      end else if (accept) begin
         in_cnt <= in_cnt + LOG2_WIN'(1);
         if (in_cnt == '1) begin
            in_bin <= in_bin + BW'(1);
         end
      end
   end

   iir_pwr_stage #(.DW(DW)) u_pwr (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (bus.sweep_start),
      .valid_in  (accept),
      .re        (bus.d_real),
      .im        (bus.d_imag),
      .valid_out (p_valid),
      .pwr       (p_pwr)
   );

   // The first sample of a window reloads rather than adds, so windows abut.
   assign acc_sum = (s_cnt == '0) ? AW'(p_pwr) : acc + AW'(p_pwr);

`ifdef IIR_METER_PEAK_EN
   logic [PW-1:0] peak;

   assign peak_next = ((s_cnt == '0) || (p_pwr > peak)) ? p_pwr : peak;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak <= '0;
      end else if (bus.sweep_start) begin
         peak <= '0;
      end else if (p_valid) begin
         peak <= peak_next;
      end
   end
`else
   assign peak_next = '0;
`endif

   // sweep_start discards whatever reaches this stage, suppressing its dv_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_cnt    <= '0;
         s_bin    <= '0;
         acc      <= '0;
         res      <= '0;
         res_dv   <= 1'b0;
         res_done <= 1'b0;
      end else begin
         res_dv   <= 1'b0;
         res_done <= 1'b0;
         if (bus.sweep_start) begin
            s_cnt <= '0;
            s_bin <= '0;
            acc   <= '0;
         end else if (p_valid) begin
            s_cnt <= s_cnt + LOG2_WIN'(1);
            acc   <= acc_sum;
            if (s_cnt == '1) begin
               res.bin  <= s_bin;
               res.mean <= PW'(acc_sum >> LOG2_WIN);
               res.peak <= peak_next;
               res_dv   <= 1'b1;
               res_done <= (s_bin == LAST_BIN);
               s_bin    <= (s_bin == LAST_BIN) ? '0 : s_bin + BW'(1);
            end
         end
      end
   end

   assign bus.dv_out     = res_dv;
   assign bus.bin        = res.bin;
   assign bus.mean_pwr   = res.mean;
   assign bus.peak_pwr   = res.peak;
   assign bus.sweep_done = res_done;
   assign bus.busy       = (state == RUN);

endmodule

// File: tb/tb_iir_response_meter.sv
// Directed bench for iir_response_meter with small windows (16 samples, 4 bins).
// Expected peak values follow IIR_METER_PEAK_EN.
module tb_iir_response_meter;

   localparam int LOG2_WIN = 4;
   localparam int NBINS    = 4;
   localparam int DW       = 18;

`ifdef IIR_METER_PEAK_EN
   localparam bit PEAK_EN = 1'b1;
`else
   localparam bit PEAK_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   nCompared   = 0;
   int   nMismatched = 0;
   int   accCyc      = 0;
   int   firstLast   = 0;
   int   lastAcc     = 0;

   int          evCyc[$];
   int          evBin[$];
   logic [63:0] evMean[$];
   logic [63:0] evPeak[$];
   int          evDone[$];

   iir_response_meter_if #(.DW(DW), .NBINS(NBINS)) mif ();

   iir_response_meter #(
      .LOG2_WIN (LOG2_WIN),
      .NBINS    (NBINS),
      .DW       (DW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mif.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Result collector, sampling 1 ns after each rising edge.
   always @(posedge clk) begin
      #1;
      if (mif.dv_out === 1'b1) begin
         evCyc.push_back(cyc);
         evBin.push_back(int'(mif.bin));
         evMean.push_back(64'(mif.mean_pwr));
         evPeak.push_back(64'(mif.peak_pwr));
         evDone.push_back(int'(mif.sweep_done));
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic logic [63:0] expPeak(input logic [63:0] v);
      return PEAK_EN ? v : 64'd0;
   endfunction

   task automatic applyStimulus(input bit start, input bit valid,
                                input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
      mif.sweep_start = start;
      mif.dv_in       = valid;
      mif.d_real      = re;
      mif.d_imag      = im;
      if (valid) accCyc = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic runSamples(input int n, input logic signed [DW-1:0] re,
                             input logic signed [DW-1:0] im, input bit start);
      for (int k = 0; k < n; k++) begin
         applyStimulus(start && (k == 0), 1'b1, re, im);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 18'sd777, -18'sd777);
   endtask

   task automatic clearEvents();
      evCyc.delete();
      evBin.delete();
      evMean.delete();
      evPeak.delete();
      evDone.delete();
   endtask

   task automatic checkZeroOutputs(input string tag);
      checkOutput({tag, "_dv_out"},     64'(mif.dv_out),     64'd0);
      checkOutput({tag, "_busy"},       64'(mif.busy),       64'd0);
      checkOutput({tag, "_bin"},        64'(mif.bin),        64'd0);
      checkOutput({tag, "_mean"},       64'(mif.mean_pwr),   64'd0);
      checkOutput({tag, "_peak"},       64'(mif.peak_pwr),   64'd0);
      checkOutput({tag, "_sweep_done"}, 64'(mif.sweep_done), 64'd0);
   endtask

   initial begin
      mif.sweep_start = 1'b0;
      mif.dv_in       = 1'b0;
      mif.d_real      = '0;
      mif.d_imag      = '0;

      repeat (3) @(posedge clk);
      #1;
      checkZeroOutputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Constant level across a full sweep, with trailing samples ignored in IDLE.
      clearEvents();
      runSamples(1, 18'sd1000, 18'sd0, 1'b1);
      firstLast = accCyc + 15;
      checkOutput("const_busy_run", 64'(mif.busy), 64'd1);
      runSamples(63, 18'sd1000, 18'sd0, 1'b0);
      lastAcc = accCyc;
      checkOutput("const_busy_drop", 64'(mif.busy), 64'd0);
      runSamples(6, 18'sd1000, 18'sd0, 1'b0);
      checkOutput("const_count", 64'(evBin.size()), 64'd4);
      for (int b = 0; b < 4 && b < evBin.size(); b++) begin
         checkOutput($sformatf("const_bin%0d", b),  64'(evBin[b]),  64'(b));
         checkOutput($sformatf("const_mean%0d", b), evMean[b],      64'd1000000);
         checkOutput($sformatf("const_peak%0d", b), evPeak[b],      expPeak(64'd1000000));
         checkOutput($sformatf("const_done%0d", b), 64'(evDone[b]), (b == 3) ? 64'd1 : 64'd0);
      end
      if (evCyc.size() >= 4) begin
         checkOutput("const_lat_first", 64'(evCyc[0]), 64'(firstLast + 3));
         checkOutput("const_lat_last",  64'(evCyc[3]), 64'(lastAcc + 3));
      end

      // Full-scale negative corner on both rails.
      clearEvents();
      runSamples(16, -18'sd131072, -18'sd131072, 1'b1);
      idleCycles(4);
      checkOutput("fs_count", 64'(evBin.size()), 64'd1);
      if (evBin.size() >= 1) begin
         checkOutput("fs_bin",  64'(evBin[0]), 64'd0);
         checkOutput("fs_mean", evMean[0],     64'd34359738368);
         checkOutput("fs_peak", evPeak[0],     expPeak(64'd34359738368));
         checkOutput("fs_done", 64'(evDone[0]), 64'd0);
      end

      // One 3+4j sample in a window of zeros.
      clearEvents();
      for (int k = 0; k < 16; k++) begin
         applyStimulus(k == 0, 1'b1, (k == 5) ? 18'sd3 : 18'sd0, (k == 5) ? 18'sd4 : 18'sd0);
      end
      idleCycles(4);
      checkOutput("pk_count", 64'(evBin.size()), 64'd1);
      if (evBin.size() >= 1) begin
         checkOutput("pk_mean", evMean[0], 64'd1);
         checkOutput("pk_peak", evPeak[0], expPeak(64'd25));
      end

      // Sparse input, one sample every 7th cycle.
      clearEvents();
      for (int k = 0; k < 16; k++) begin
         applyStimulus(k == 0, 1'b1, 18'sd2000, -18'sd1500);
         if (k < 15) idleCycles(6);
      end
      lastAcc = accCyc;
      idleCycles(4);
      checkOutput("sparse_count", 64'(evBin.size()), 64'd1);
      if (evBin.size() >= 1) begin
         checkOutput("sparse_mean", evMean[0],     64'd6250000);
         checkOutput("sparse_peak", evPeak[0],     expPeak(64'd6250000));
         checkOutput("sparse_lat",  64'(evCyc[0]), 64'(lastAcc + 3));
      end

      // Abort partway through bin 2, then a fresh sweep.
      clearEvents();
      runSamples(32, 18'sd1000, 18'sd0, 1'b1);
      runSamples(9, 18'sd1000, 18'sd0, 1'b0);
      runSamples(16, 18'sd0, 18'sd500, 1'b1);
      idleCycles(4);
      checkOutput("abort_count", 64'(evBin.size()), 64'd3);
      if (evBin.size() >= 3) begin
         checkOutput("abort_bin1",  64'(evBin[1]), 64'd1);
         checkOutput("abort_bin",   64'(evBin[2]), 64'd0);
         checkOutput("abort_mean",  evMean[2],     64'd250000);
         checkOutput("abort_peak",  evPeak[2],     expPeak(64'd250000));
      end

      // Restart one cycle after a window's last sample: result is in flight.
      clearEvents();
      runSamples(16, 18'sd1000, 18'sd0, 1'b1);
      applyStimulus(1'b1, 1'b0, 18'sd0, 18'sd0);
      idleCycles(5);
      checkOutput("inflight_count", 64'(evBin.size()), 64'd0);
      checkOutput("inflight_busy",  64'(mif.busy),     64'd1);

      // Reset during bin 1.
      clearEvents();
      runSamples(21, 18'sd1000, 18'sd0, 1'b1);
      checkOutput("rst_pre_count", 64'(evBin.size()), 64'd1);
      checkOutput("rst_pre_mean",  64'(mif.mean_pwr), 64'd1000000);
      rst_n = 1'b0;
      #1;
      checkZeroOutputs("midrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clearEvents();
      runSamples(100, 18'sd1000, 18'sd0, 1'b0);
      checkOutput("postrst_count", 64'(evBin.size()), 64'd0);
      checkOutput("postrst_busy",  64'(mif.busy),     64'd0);
      runSamples(16, 18'sd300, -18'sd400, 1'b1);
      idleCycles(4);
      checkOutput("postrst_run_count", 64'(evBin.size()), 64'd1);
      if (evBin.size() >= 1) begin
         checkOutput("postrst_bin",  64'(evBin[0]), 64'd0);
         checkOutput("postrst_mean", evMean[0],     64'd250000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
